// File: rtl/xbar_ctrl_issuer.sv
// Crossbar control issuer: queues routing-config requests and issues each one to
// its target crossbar only after that target's datapath has been quiet long enough.

module xbar_ctrl_issuer_lane #(
  parameter int CONTROL_BIT_WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic                         clear,
  input  logic [CONTROL_BIT_WIDTH-1:0] word,
  output logic                         val,
  output logic [CONTROL_BIT_WIDTH-1:0] msg
);
  always_ff @(posedge clk) begin
    if (reset) begin
      val <= 1'b0;
      msg <= '0;
    end else if (load) begin
      val <= 1'b1;
      msg <= word;
    end else if (clear) begin
      val <= 1'b0;
      msg <= '0;
    end
  end
endmodule

module xbar_ctrl_issuer #(
  parameter int CONTROL_BIT_WIDTH = 2,
  parameter int N_TARGETS         = 4,
  parameter int TGT_W             = 2,
  parameter int DEPTH             = 4,
  parameter int QUIET_CYCLES      = 2,
  parameter int COUNT_W           = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [TGT_W+CONTROL_BIT_WIDTH-1:0]     req_msg,
  input  logic                                   req_val,
  output logic                                   req_rdy,
  output logic [N_TARGETS*CONTROL_BIT_WIDTH-1:0] ctrl_msg,
  output logic [N_TARGETS-1:0]                   ctrl_val,
  input  logic [N_TARGETS-1:0]                   ctrl_rdy,
  input  logic [N_TARGETS-1:0]                   tgt_busy,
  output logic [COUNT_W-1:0]                     issued_count,
  output logic                                   err
);
  localparam int MSG_W  = TGT_W + CONTROL_BIT_WIDTH;
  localparam int AW     = $clog2(DEPTH);
  localparam int QW     = $clog2(QUIET_CYCLES + 1);
  localparam int NT_PAD = 1 << TGT_W;

  typedef enum logic [1:0] {IDLE, DRAIN, ISSUE} state_t;

  state_t                 state;
  logic [TGT_W-1:0]       tgt;
  logic [QW-1:0]          qcnt;

  logic [MSG_W-1:0]       mem [DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            occ;
  logic                   full, empty, push, pop;

  logic [MSG_W-1:0]             head;
  logic [TGT_W-1:0]             head_tgt;
  logic [CONTROL_BIT_WIDTH-1:0] head_word;
  logic                         head_bad;

  logic [NT_PAD-1:0]      busy_pad, rdy_pad;
  logic                   busy_sel, rdy_sel, quiet_done, issue_load, issue_done;

  // ---------------- request FIFO ----------------
  assign full    = (occ == (AW+1)'(DEPTH));
  assign empty   = (occ == '0);
  assign req_rdy = !full;
  assign push    = req_val && !full;

  assign head      = mem[rd_ptr];
  assign head_tgt  = head[MSG_W-1 -: TGT_W];
  assign head_word = head[CONTROL_BIT_WIDTH-1:0];
  assign head_bad  = ({{(32-TGT_W){1'b0}}, head_tgt} >= 32'(N_TARGETS));

  // Bad heads are dropped from IDLE; good heads leave only on the target handshake.
  assign pop = ((state == IDLE) && !empty && head_bad) || issue_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= req_msg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // ---------------- target selection ----------------
  // Pad to the full id space so the latched id indexes without width games.
  assign busy_pad = NT_PAD'(tgt_busy);
  assign rdy_pad  = NT_PAD'(ctrl_rdy);
  assign busy_sel = busy_pad[tgt];
  assign rdy_sel  = rdy_pad[tgt];

  assign quiet_done = !busy_sel && (qcnt == QW'(QUIET_CYCLES - 1));
  assign issue_load = (state == DRAIN) && quiet_done;
  assign issue_done = (state == ISSUE) && rdy_sel;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tgt          <= '0;
      qcnt         <= '0;
      issued_count <= '0;
      err          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            if (head_bad) begin
              err <= 1'b1;
            end else begin
              tgt   <= head_tgt;
              qcnt  <= '0;
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (busy_sel) begin
            qcnt <= '0;
          end else if (quiet_done) begin
            qcnt  <= '0;
            state <= ISSUE;
          end else begin
            qcnt <= qcnt + 1'b1;
          end
        end
        ISSUE: begin
          if (rdy_sel) begin
            issued_count <= issued_count + 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------- per-target output registers ----------------
  for (genvar i = 0; i < N_TARGETS; i++) begin : g_lane
    xbar_ctrl_issuer_lane #(
      .CONTROL_BIT_WIDTH(CONTROL_BIT_WIDTH)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .load  (issue_load && (tgt == TGT_W'(i))),
      .clear (issue_done),
      .word  (head_word),
      .val   (ctrl_val[i]),
      .msg   (ctrl_msg[i*CONTROL_BIT_WIDTH +: CONTROL_BIT_WIDTH])
    );
  end
endmodule

// File: tb/tb_xbar_ctrl_issuer.sv
// Directed bench for xbar_ctrl_issuer: queue-based reference model checked every
// cycle on the default instance, plus literal checks and a 3-target instance.

module tb_xbar_ctrl_issuer;
  localparam int NT = 4, DEP = 4, QC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_msg;
  logic       req_val;
  logic       req_rdy;
  logic [7:0] ctrl_msg;
  logic [3:0] ctrl_val, ctrl_rdy, tgt_busy;
  logic [7:0] issued_count;
  logic       err;

  logic       rst3;
  logic [3:0] rm3;
  logic       rv3, rr3;
  logic [5:0] cm3;
  logic [2:0] cv3, crdy3, busy3;
  logic [7:0] cnt3;
  logic       err3;

  int n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  xbar_ctrl_issuer u_dut (
    .clk(clk), .reset(reset), .req_msg(req_msg), .req_val(req_val), .req_rdy(req_rdy),
    .ctrl_msg(ctrl_msg), .ctrl_val(ctrl_val), .ctrl_rdy(ctrl_rdy), .tgt_busy(tgt_busy),
    .issued_count(issued_count), .err(err)
  );

  xbar_ctrl_issuer #(.N_TARGETS(3)) u_dut3 (
    .clk(clk), .reset(rst3), .req_msg(rm3), .req_val(rv3), .req_rdy(rr3),
    .ctrl_msg(cm3), .ctrl_val(cv3), .ctrl_rdy(crdy3), .tgt_busy(busy3),
    .issued_count(cnt3), .err(err3)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: pending requests in a queue; phase 0 = waiting for pickup,
  // 1 = watching the target for a quiet run, 2 = word offered to the target.
  logic [3:0] mq[$];
  int         mph = 0, mtgt = 0, mrun = 0;
  logic [7:0] mcnt = 0;
  logic       merr = 0;
  bit         mlive = 0;

  always @(posedge clk) begin
    logic [3:0] h;
    bit push, pop;
    if (reset) begin
      mq.delete(); mph = 0; mtgt = 0; mrun = 0; mcnt = 0; merr = 0; mlive = 1;
    end else if (mlive) begin
      push = req_val && (mq.size() < DEP);
      pop  = 0;
      case (mph)
        0: if (mq.size() > 0) begin
             h = mq[0];
             if (int'(h[3:2]) >= NT) begin pop = 1; merr = 1; end
             else begin mtgt = int'(h[3:2]); mrun = 0; mph = 1; end
           end
        1: begin
             if (tgt_busy[mtgt]) mrun = 0; else mrun++;
             if (mrun == QC) mph = 2;
           end
        default: if (ctrl_rdy[mtgt]) begin pop = 1; mcnt++; mph = 0; end
      endcase
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(req_msg);
    end
  end

  always @(negedge clk) begin
    logic [3:0] ev, h;
    logic [7:0] em;
    if (mlive) begin
      ev = '0; em = '0;
      if (mph == 2) begin
        h = mq[0];
        ev[mtgt] = 1'b1;
        em = {6'b0, h[1:0]} << (2 * mtgt);
      end
      chk("m_req_rdy", 32'(req_rdy), 32'(mq.size() < DEP));
      chk("m_ctrl_val", 32'(ctrl_val), 32'(ev));
      chk("m_ctrl_msg", 32'(ctrl_msg), 32'(em));
      chk("m_issued_count", 32'(issued_count), 32'(mcnt));
      chk("m_err", 32'(err), 32'(merr));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    bit seen;
    logic [3:0] seq [5] = '{4'b0001, 4'b0110, 4'b1011, 4'b1101, 4'b0010};

    reset = 1; req_val = 0; req_msg = '0; ctrl_rdy = 4'hF; tgt_busy = '0;
    rst3 = 1; rv3 = 0; rm3 = '0; crdy3 = 3'b111; busy3 = '0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl_val", 32'(ctrl_val), 0);
    chk("rst_ctrl_msg", 32'(ctrl_msg), 0);
    chk("rst_count", 32'(issued_count), 0);
    chk("rst_err", 32'(err), 0);
    reset = 0; rst3 = 0;
    @(negedge clk);
    chk("rst_req_rdy", 32'(req_rdy), 1);

    // T1: single request to target 1, issue 4 cycles after acceptance
    req_val = 1; req_msg = {2'd1, 2'b10};
    @(negedge clk);
    req_val = 0;
    for (int k = 0; k <= 4; k++) begin
      chk("t1_val", 32'(ctrl_val), (k == 3) ? 32'h2 : 32'h0);
      if (k == 3) chk("t1_msg", 32'(ctrl_msg), 32'h08);
      if (k == 4) chk("t1_count", 32'(issued_count), 1);
      @(negedge clk);
    end

    // T2: busy pattern 1,0,1,0,0 on target 2 during the quiet watch
    tgt_busy = 4'b0100;
    req_val = 1; req_msg = {2'd2, 2'b01};
    @(negedge clk);
    req_val = 0;
    for (int k = 0; k <= 7; k++) begin
      chk("t2_val", 32'(ctrl_val), (k == 6) ? 32'h4 : 32'h0);
      if (k == 6) chk("t2_msg", 32'(ctrl_msg), 32'h10);
      if (k == 7) chk("t2_count", 32'(issued_count), 2);
      if (k >= 1 && k <= 5) tgt_busy[2] = pat[k-1];
      if (k == 6) tgt_busy = '0;
      @(negedge clk);
    end

    // T3: target 3 holds off ready for 5 cycles
    ctrl_rdy = 4'b0111;
    req_val = 1; req_msg = {2'd3, 2'b11};
    @(negedge clk);
    req_val = 0;
    for (int k = 0; k <= 8; k++) begin
      chk("t3_val", 32'(ctrl_val), (k >= 3 && k <= 7) ? 32'h8 : 32'h0);
      if (k >= 3 && k <= 7) chk("t3_msg", 32'(ctrl_msg), 32'hC0);
      if (k == 7) chk("t3_count_hold", 32'(issued_count), 2);
      if (k == 7) ctrl_rdy = 4'hF;
      if (k == 8) chk("t3_count", 32'(issued_count), 3);
      @(negedge clk);
    end

    // T4: five back-to-back pushes against a full FIFO with everything busy
    tgt_busy = 4'hF;
    req_val = 1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_rdy_open", 32'(req_rdy), 1);
      req_msg = seq[i];
      @(negedge clk);
    end
    req_msg = seq[4];
    for (int i = 0; i < 3; i++) begin
      chk("t4_rdy_full", 32'(req_rdy), 0);
      @(negedge clk);
    end
    tgt_busy = '0;
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      if (req_rdy) seen = 1; else @(negedge clk);
    end
    chk("t4_rdy_return", 32'(seen), 1);
    @(negedge clk);
    req_val = 0;
    for (int t = 0; t < 40 && issued_count != 8'd8; t++) @(negedge clk);
    chk("t4_count", 32'(issued_count), 8);

    // T6: reset while issuing with 2 entries behind the head
    ctrl_rdy = 4'b1101;
    req_val = 1;
    for (int i = 0; i < 3; i++) begin
      req_msg = {2'd1, 2'(i + 1)};
      @(negedge clk);
    end
    req_val = 0;
    seen = 0;
    for (int t = 0; t < 12 && !seen; t++) begin
      if (ctrl_val[1]) seen = 1; else @(negedge clk);
    end
    chk("t6_in_issue", 32'(seen), 1);
    reset = 1;
    @(negedge clk);
    chk("t6_val", 32'(ctrl_val), 0);
    chk("t6_count", 32'(issued_count), 0);
    chk("t6_err", 32'(err), 0);
    chk("t6_rdy", 32'(req_rdy), 1);
    reset = 0; ctrl_rdy = 4'hF;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t6_empty_val", 32'(ctrl_val), 0);
    end

    // T5: 3-target instance, id 3 is out of range
    rv3 = 1; rm3 = {2'd3, 2'b01};
    @(negedge clk);
    rv3 = 0;
    chk("t5_err_pre", 32'(err3), 0);
    @(negedge clk);
    chk("t5_err_set", 32'(err3), 1);
    chk("t5_no_val", 32'(cv3), 0);
    chk("t5_count0", 32'(cnt3), 0);
    rv3 = 1; rm3 = {2'd1, 2'b10};
    @(negedge clk);
    rv3 = 0;
    for (int k = 0; k <= 4; k++) begin
      chk("t5_val", 32'(cv3), (k == 3) ? 32'h2 : 32'h0);
      if (k == 3) chk("t5_msg", 32'(cm3), 32'h08);
      chk("t5_err_sticky", 32'(err3), 1);
      if (k == 4) chk("t5_count", 32'(cnt3), 1);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
